alu_mdu: RTL

- Parametrised successor ALU: XLEN-generic base integer ops plus RV32M/RV64M multiply/divide.
- Base ops finish in 1 cycle. MUL*/DIV*/REM* use an iterative radix-2 datapath with a valid/ready handshake.
- Sits in the EXEC stage. The core stalls while in_ready=0.
- Supports flush (kill) of an in-flight multi-cycle operation.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mdu_if.sv | 10 +
 rtl/mdu_iter.sv | 46 ++++
 rtl/alu_mdu.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and FSM state type for the alu_mdu execution unit.
package alu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;
endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/result handshake between the core EXEC stage and alu_mdu.
interface alu_mdu_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready, kill, mext, out_valid;
  logic [XLEN-1:0] aluin1, aluin2, aluout;
  logic [3:0]      funct_alu;
  modport master(output in_valid, kill, aluin1, aluin2, funct_alu, mext,
                 input in_ready, out_valid, aluout);
  modport slave(input in_valid, kill, aluin1, aluin2, funct_alu, mext,
                output in_ready, out_valid, aluout);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 shift-add multiply / restoring divide over unsigned magnitudes.
module mdu_iter #(parameter int XLEN = 32) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                step_i,
  input  logic                div_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output logic [2*XLEN-1:0]   acc_o,
  output logic                last_o
);
  localparam int CW = $clog2(XLEN);
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q;
  logic              div_q;
  logic [XLEN:0]     add, shl, sub;
  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shl   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    sub   = shl - {1'b0, b_q};
    acc_d = !div_q ? {add, acc_q[XLEN-1:1]} :
            sub[XLEN] ? {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                        {sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= {{XLEN{1'b0}}, a_i};
      b_q   <= b_i;
      cnt_q <= CW'(XLEN - 1);
      div_q <= div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end
  assign acc_o  = acc_q;
  assign last_o = cnt_q == '0;
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle base ALU plus iterative RV32M/RV64M multiply/divide.
// Define ALU_MDU_FAST_MUL_EN to resolve multiplies with a combinational multiplier.
module alu_mdu import alu_pkg::*; #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       rst_n,
  alu_mdu_if.slave  ifc
);
  localparam int SHW = $clog2(XLEN);
  state_e            state_q;
  logic              out_valid_q, neg_q, rneg_q;
  logic [2:0]        op_q, f3;
  logic [XLEN-1:0]   aluout_q, a, b, mag1, mag2, base_res, quick_res, fast_res, fix_res, fix_q, fix_r;
  logic [2*XLEN-1:0] acc, fix_p;
  logic [SHW-1:0]    sh;
  logic              b3, s1, s2, n1, n2, div0, ovf, fast_mul, quick, accept, start, last;
  assign a  = ifc.aluin1;
  assign b  = ifc.aluin2;
  assign f3 = ifc.funct_alu[2:0];
  assign b3 = ifc.funct_alu[3];
  assign sh = b[SHW-1:0];
  always_comb begin
    base_res = '0;
    case (f3)
      F3_ADD:  base_res = b3 ? a - b : a + b;
      F3_SLL:  base_res = a << sh;
      F3_SLT:  base_res = b3 ? '0 : {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: base_res = b3 ? '0 : {{(XLEN-1){1'b0}}, a < b};
      F3_XOR:  base_res = a ^ b;
      F3_SR:   base_res = b3 ? $unsigned($signed(a) >>> sh) : a >> sh;
      F3_OR:   base_res = a | b;
      default: base_res = a & b;
    endcase
  end
  // operands become magnitudes here; result signs are captured alongside them
  assign s1   = f3 == M_MULH || f3 == M_MULHSU || f3 == M_DIV || f3 == M_REM;
  assign s2   = f3 == M_MULH || f3 == M_DIV || f3 == M_REM;
  assign n1   = s1 & a[XLEN-1];
  assign n2   = s2 & b[XLEN-1];
  assign mag1 = n1 ? -a : a;
  assign mag2 = n2 ? -b : b;
  assign div0 = f3[2] && b == '0;
  assign ovf  = (f3 == M_DIV || f3 == M_REM) && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p, fast_ps;
  assign fast_p   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  assign fast_ps  = (n1 ^ n2) ? -fast_p : fast_p;
  assign fast_res = f3 == M_MUL ? fast_ps[XLEN-1:0] : fast_ps[2*XLEN-1:XLEN];
  assign fast_mul = ~f3[2];
`else
  assign fast_res = '0;
  assign fast_mul = 1'b0;
`endif
  assign quick     = ~ifc.mext | div0 | ovf | fast_mul;
  assign quick_res = ~ifc.mext ? base_res :
                     div0      ? (f3[1] ? a : '1) :
                     ovf       ? (f3[1] ? '0 : a) : fast_res;
  assign accept    = ifc.in_valid & (state_q == IDLE) & ~ifc.kill;
  assign start     = accept & ~quick;
  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk(clk), .rst_n(rst_n), .start_i(start), .step_i(state_q == CALC),
    .div_i(f3[2]), .a_i(mag1), .b_i(mag2), .acc_o(acc), .last_o(last)
  );
  assign fix_p   = neg_q ? -acc : acc;
  assign fix_q   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign fix_r   = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = op_q[2] ? (op_q[1] ? fix_r : fix_q) :
                   (op_q == M_MUL ? fix_p[XLEN-1:0] : fix_p[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (ifc.kill) state_q <= IDLE;
      else case (state_q)
        IDLE: if (accept) begin
          if (quick) begin
            aluout_q    <= quick_res;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= CALC;
            op_q    <= f3;
            neg_q   <= n1 ^ n2;
            rneg_q  <= n1;
          end
        end
        CALC: if (last) state_q <= FIXUP;
        FIXUP: begin
          state_q     <= IDLE;
          aluout_q    <= fix_res;
          out_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ifc.in_ready  = state_q == IDLE;
  assign ifc.out_valid = out_valid_q;
  assign ifc.aluout    = aluout_q;
endmodule
